// File: rtl/alpha68k_pkg.sv
// Shared definitions for the alpha68k CPU-side bus blocks.
// Holds the arbiter state encoding and the requester index width.
package alpha68k_pkg;

   localparam int ARB_OWNER_W = 3;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_REQUEST = 3'd1,
      ST_WAIT_AS = 3'd2,
      ST_OWNED   = 3'd3,
      ST_RELEASE = 3'd4
   } arb_state_t;

endpackage

// File: rtl/cpu_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo N, returned both one-hot and as an index.
module rr_pick
   import alpha68k_pkg::*;
#(
   parameter int N = 2,
   parameter int W = ARB_OWNER_W
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] onehot,
   output logic [W-1:0] index
);

   always_comb begin
      int   j;
      logic found;
      onehot = '0;
      index  = '0;
      found  = 1'b0;
      j      = 0;
      for (int i = 0; i < N; i++) begin
         j = (int'(ptr) + i) % N;
         if (!found && req[j]) begin
            found     = 1'b1;
            onehot[j] = 1'b1;
            index     = W'(j);
         end
      end
   end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Shares the 68000 bus between the CPU and N_REQ DMA-style requesters using
// the nBR/nBG/nBGACK handshake; one round-robin grant at a time, optional hold limit.
module cpu_bus_arbiter
   import alpha68k_pkg::*;
#(
   parameter int N_REQ    = 2,
   parameter int MAX_HOLD = 1024,
   parameter int HOLD_W   = 11
) (
   input  logic                   CLK_24M,
   input  logic                   RESET,
   input  logic [N_REQ-1:0]       REQ,
   output logic [N_REQ-1:0]       GNT,
   input  logic                   nBG,
   input  logic                   nAS,
   output logic                   nBR,
   output logic                   nBGACK,
   output logic [ARB_OWNER_W-1:0] OWNER,
   output logic                   HOLD_ERR,
   output logic [2:0]             STATE_DBG
);

   // Requester handshake: REQ[i] is a level held high until the requester is
   // done; GNT[i] is a level and the requester may drive the bus only while it
   // is high. Dropping REQ[i] while granted ends the tenure on the next edge.

   localparam bit                HOLD_LIMITED = (MAX_HOLD != 0);
   localparam logic [HOLD_W-1:0] HOLD_LAST    = HOLD_LIMITED ? HOLD_W'(MAX_HOLD - 1) : '0;

   arb_state_t             state, state_nx;
   logic                   nbg_q, nas_q;
   logic [ARB_OWNER_W-1:0] rr_ptr, rr_ptr_nx;
   logic [HOLD_W-1:0]      hold_cnt, hold_cnt_nx;
   logic [N_REQ-1:0]       gnt_nx;
   logic [ARB_OWNER_W-1:0] owner_nx;
   logic                   nbr_nx, nbgack_nx, hold_err_nx;
   logic [N_REQ-1:0]       pick_onehot;
   logic [ARB_OWNER_W-1:0] pick_index;
   logic                   req_any, owner_req;

   rr_pick #(
      .N (N_REQ),
      .W (ARB_OWNER_W)
   ) u_rr_pick (
      .req    (REQ),
      .ptr    (rr_ptr),
      .onehot (pick_onehot),
      .index  (pick_index)
   );

   assign req_any   = |REQ;
   // GNT is one-hot in OWNED, so this is REQ of the current owner.
   assign owner_req = |(REQ & GNT);
   assign STATE_DBG = state;

   always_ff @(posedge CLK_24M) begin
      if (RESET) begin
         state    <= ST_IDLE;
         nbg_q    <= 1'b1;
         nas_q    <= 1'b1;
         rr_ptr   <= '0;
         hold_cnt <= '0;
         GNT      <= '0;
         OWNER    <= '0;
         nBR      <= 1'b1;
         nBGACK   <= 1'b1;
         HOLD_ERR <= 1'b0;
      end else begin
         state    <= state_nx;
         nbg_q    <= nBG;
         nas_q    <= nAS;
         rr_ptr   <= rr_ptr_nx;
         hold_cnt <= hold_cnt_nx;
         GNT      <= gnt_nx;
         OWNER    <= owner_nx;
         nBR      <= nbr_nx;
         nBGACK   <= nbgack_nx;
         HOLD_ERR <= hold_err_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      rr_ptr_nx   = rr_ptr;
      hold_cnt_nx = hold_cnt;
      gnt_nx      = GNT;
      owner_nx    = OWNER;
      nbr_nx      = nBR;
      nbgack_nx   = nBGACK;
      hold_err_nx = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (req_any) begin
               nbr_nx   = 1'b0;
               state_nx = ST_REQUEST;
            end
         end
         ST_REQUEST: begin
            if (!req_any) begin
               nbr_nx   = 1'b1;
               state_nx = ST_IDLE;
            end else if (!nbg_q) begin
               state_nx = ST_WAIT_AS;
            end
         end
         ST_WAIT_AS: begin
            // Take the bus only once the CPU's last cycle has ended and our own
            // acknowledge is not still asserted from a previous tenure.
            if (!req_any) begin
               nbr_nx   = 1'b1;
               state_nx = ST_IDLE;
            end else if (nas_q && nBGACK) begin
               nbgack_nx   = 1'b0;
               nbr_nx      = 1'b1;
               gnt_nx      = pick_onehot;
               owner_nx    = pick_index;
               hold_cnt_nx = '0;
               state_nx    = ST_OWNED;
            end
         end
         ST_OWNED: begin
            hold_cnt_nx = (&hold_cnt) ? hold_cnt : hold_cnt + HOLD_W'(1);
            if (!owner_req) begin
               gnt_nx   = '0;
               state_nx = ST_RELEASE;
            end else if (HOLD_LIMITED && (hold_cnt == HOLD_LAST)) begin
               gnt_nx      = '0;
               hold_err_nx = 1'b1;
               state_nx    = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            // One cycle with GNT low lets the requester float its strobes
            // before the CPU sees the bus handed back.
            nbgack_nx = 1'b1;
            rr_ptr_nx = (OWNER == ARB_OWNER_W'(N_REQ - 1)) ? '0 : OWNER + ARB_OWNER_W'(1);
            state_nx  = ST_IDLE;
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed bench for cpu_bus_arbiter: single grant, contention and fairness,
// nAS busy, withdrawal, hold timeout and reset during a grant.
module tb_cpu_bus_arbiter;
   import alpha68k_pkg::*;

   localparam int N_REQ    = 2;
   localparam int MAX_HOLD = 16;
   localparam int HOLD_W   = 5;

   logic                   CLK_24M = 1'b0;
   logic                   RESET   = 1'b1;
   logic [N_REQ-1:0]       REQ     = '0;
   logic [N_REQ-1:0]       GNT;
   logic                   nBG     = 1'b1;
   logic                   nAS     = 1'b1;
   logic                   nBR;
   logic                   nBGACK;
   logic [ARB_OWNER_W-1:0] OWNER;
   logic                   HOLD_ERR;
   logic [2:0]             STATE_DBG;

   int n_cmp = 0;
   int n_bad = 0;
   logic [ARB_OWNER_W-1:0] exp_q[$];
   logic [N_REQ-1:0]       prev_gnt = '0;

   cpu_bus_arbiter #(
      .N_REQ    (N_REQ),
      .MAX_HOLD (MAX_HOLD),
      .HOLD_W   (HOLD_W)
   ) dut (
      .CLK_24M   (CLK_24M),
      .RESET     (RESET),
      .REQ       (REQ),
      .GNT       (GNT),
      .nBG       (nBG),
      .nAS       (nAS),
      .nBR       (nBR),
      .nBGACK    (nBGACK),
      .OWNER     (OWNER),
      .HOLD_ERR  (HOLD_ERR),
      .STATE_DBG (STATE_DBG)
   );

   // clock / reset
   always #21 CLK_24M = ~CLK_24M;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock; outputs sampled 1 time unit after the edge. Every new grant
   // is scored against the owner queued by the stimulus.
   task automatic tick();
      logic [ARB_OWNER_W-1:0] e;
      @(posedge CLK_24M);
      #1;
      check("gnt_onehot0", 32'($onehot0(GNT)), 32'd1);
      if (GNT != '0 && prev_gnt == '0) begin
         if (exp_q.size() == 0) begin
            check("gnt_unexpected", 32'(GNT), 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("gnt_owner", 32'(OWNER), 32'(e));
            check("gnt_vector", 32'(GNT), 32'd1 << e);
         end
      end
      prev_gnt = GNT;
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      REQ   = '0;
      nBG   = 1'b1;
      nAS   = 1'b1;
      tick();
      tick();
      RESET = 1'b0;
   endtask

   // CPU model: assert nBG and wait the register stage plus two FSM cycles.
   task automatic cpu_grant(input logic [ARB_OWNER_W-1:0] who);
      exp_q.push_back(who);
      nBG = 1'b0;
      repeat (3) tick();
      nBG = 1'b1;
   endtask

   int hi, errs, n;

   initial begin
      // 1: reset state and single requester
      do_reset();
      check("rst_nbr", 32'(nBR), 32'd1);
      check("rst_nbgack", 32'(nBGACK), 32'd1);
      check("rst_gnt", 32'(GNT), 32'd0);
      check("rst_owner", 32'(OWNER), 32'd0);
      check("rst_hold_err", 32'(HOLD_ERR), 32'd0);
      check("rst_state", 32'(STATE_DBG), 32'(ST_IDLE));
      REQ = 2'b01;
      tick();
      check("t1_nbr_low", 32'(nBR), 32'd0);
      check("t1_state_req", 32'(STATE_DBG), 32'(ST_REQUEST));
      repeat (4) tick();
      check("t1_gnt_before_bg", 32'(GNT), 32'd0);
      exp_q.push_back(0);
      nBG = 1'b0;
      tick();
      check("t1_gnt_lat1", 32'(GNT), 32'd0);
      tick();
      check("t1_gnt_lat2", 32'(GNT), 32'd0);
      check("t1_state_wait", 32'(STATE_DBG), 32'(ST_WAIT_AS));
      tick();
      check("t1_gnt", 32'(GNT), 32'd1);
      check("t1_nbgack_low", 32'(nBGACK), 32'd0);
      check("t1_nbr_high", 32'(nBR), 32'd1);
      nBG = 1'b1;
      repeat (3) tick();
      check("t1_gnt_held", 32'(GNT), 32'd1);
      REQ = 2'b00;
      tick();
      check("t1_gnt_drop", 32'(GNT), 32'd0);
      check("t1_nbgack_still", 32'(nBGACK), 32'd0);
      tick();
      check("t1_nbgack_rel", 32'(nBGACK), 32'd1);
      check("t1_state_idle", 32'(STATE_DBG), 32'(ST_IDLE));
      tick();
      check("t1_nbr_quiet", 32'(nBR), 32'd1);

      // 2: contention, fairness, no pre-emption
      do_reset();
      REQ = 2'b11;
      tick();
      check("t2_nbr_low", 32'(nBR), 32'd0);
      repeat (2) tick();
      cpu_grant(0);
      check("t2_gnt0", 32'(GNT), 32'd1);
      tick();
      REQ = 2'b10;
      tick();
      check("t2_gnt_drop", 32'(GNT), 32'd0);
      check("t2_nbgack_still", 32'(nBGACK), 32'd0);
      tick();
      check("t2_nbgack_rel", 32'(nBGACK), 32'd1);
      // requester 0 comes back; it was just served so requester 1 must win
      REQ = 2'b11;
      tick();
      check("t2_nbr_rereq", 32'(nBR), 32'd0);
      cpu_grant(1);
      check("t2_gnt1", 32'(GNT), 32'd2);
      check("t2_owner1", 32'(OWNER), 32'd1);
      check("t2_nbr_high", 32'(nBR), 32'd1);
      repeat (3) tick();
      check("t2_no_preempt", 32'(GNT), 32'd2);

      // 6: reset while owned
      RESET = 1'b1;
      tick();
      check("t6_nbr", 32'(nBR), 32'd1);
      check("t6_nbgack", 32'(nBGACK), 32'd1);
      check("t6_gnt", 32'(GNT), 32'd0);
      check("t6_owner", 32'(OWNER), 32'd0);
      check("t6_state", 32'(STATE_DBG), 32'(ST_IDLE));

      // 3: CPU still has nAS low when it grants
      do_reset();
      nAS = 1'b0;
      REQ = 2'b01;
      tick();
      exp_q.push_back(0);
      nBG = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("t3_gnt_busy", 32'(GNT), 32'd0);
         check("t3_nbgack_busy", 32'(nBGACK), 32'd1);
      end
      nAS = 1'b1;
      tick();
      check("t3_gnt_sync", 32'(GNT), 32'd0);
      check("t3_nbgack_sync", 32'(nBGACK), 32'd1);
      tick();
      check("t3_gnt", 32'(GNT), 32'd1);
      check("t3_nbgack", 32'(nBGACK), 32'd0);
      nBG = 1'b1;
      REQ = 2'b00;
      repeat (2) tick();
      check("t3_nbgack_rel", 32'(nBGACK), 32'd1);

      // 4: one-cycle request withdrawn before grant
      do_reset();
      REQ = 2'b01;
      tick();
      check("t4_nbr_low", 32'(nBR), 32'd0);
      REQ = 2'b00;
      tick();
      check("t4_nbr_high", 32'(nBR), 32'd1);
      check("t4_state_idle", 32'(STATE_DBG), 32'(ST_IDLE));
      repeat (4) tick();
      check("t4_gnt", 32'(GNT), 32'd0);
      check("t4_nbr_quiet", 32'(nBR), 32'd1);

      // 5: hold timeout then re-arbitration
      do_reset();
      REQ = 2'b01;
      tick();
      cpu_grant(0);
      check("t5_gnt", 32'(GNT), 32'd1);
      hi   = 1;
      errs = 0;
      n    = 0;
      while (GNT != '0 && n < 40) begin
         tick();
         n++;
         if (HOLD_ERR) errs++;
         if (GNT != '0) hi++;
      end
      check("t5_gnt_cycles", 32'(hi), 32'd16);
      check("t5_hold_err_at_drop", 32'(HOLD_ERR), 32'd1);
      tick();
      check("t5_hold_err_pulse", 32'(HOLD_ERR), 32'd0);
      check("t5_nbgack_rel", 32'(nBGACK), 32'd1);
      check("t5_err_count", 32'(errs), 32'd1);
      tick();
      check("t5_nbr_rereq", 32'(nBR), 32'd0);
      cpu_grant(0);
      check("t5_regrant", 32'(GNT), 32'd1);
      REQ = 2'b00;
      repeat (2) tick();
      check("t5_nbgack_end", 32'(nBGACK), 32'd1);

      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
